cfg_bus_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the TSS global configuration bus (19-bit address, addr_fixed flag, 32-bit data, one-cycle wr/rd strobes, one-cycle registered read response). The block shares that bus between two masters, for example the host configuration channel and the local management engine. It issues exactly one transaction at a time, matches the read response back to the issuing master, and converts a missing response into a timed-out error completion. It sits between the configuration masters and all bus slaves, including the global register block.

---
 rtl/cfg_bus_arbiter_pkg.sv | 16 +
 rtl/cfg_bus_arbiter_if.sv | 52 +++++
 rtl/cfg_bus_arbiter_rr.sv | 23 ++
 rtl/cfg_bus_arbiter.sv | 149 ++++++++++++++
 tb/tb_cfg_bus_arbiter.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cfg_bus_arbiter_pkg.sv
// Shared constants and types for the configuration bus arbiter.
package cfg_bus_pkg;
  localparam int unsigned ADDR_W = 19;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned TCNT_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RSP,
    HOLD
  } state_t;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;
endpackage

// File: rtl/cfg_bus_arbiter_if.sv
// Requester handshakes plus the shared config bus, as seen by the arbiter
// (master) and by the surrounding requesters and slaves (slave).
interface cfg_bus_arbiter_if;
  import cfg_bus_pkg::*;

  logic              i_a_req;
  logic [ADDR_W-1:0] iv_a_addr;
  logic              i_a_addr_fixed;
  logic [DATA_W-1:0] iv_a_wdata;
  logic              i_a_write;
  logic              o_a_ack;
  logic [DATA_W-1:0] ov_a_rdata;
  logic              o_a_err;

  logic              i_b_req;
  logic [ADDR_W-1:0] iv_b_addr;
  logic              i_b_addr_fixed;
  logic [DATA_W-1:0] iv_b_wdata;
  logic              i_b_write;
  logic              o_b_ack;
  logic [DATA_W-1:0] ov_b_rdata;
  logic              o_b_err;

  logic              o_wr;
  logic              o_rd;
  logic [ADDR_W-1:0] ov_addr;
  logic              o_addr_fixed;
  logic [DATA_W-1:0] ov_wdata;

  logic              i_rsp_wr;
  logic [ADDR_W-1:0] iv_rsp_addr;
  logic              i_rsp_addr_fixed;
  logic [DATA_W-1:0] iv_rsp_rdata;

  modport master (
    input  i_a_req, iv_a_addr, i_a_addr_fixed, iv_a_wdata, i_a_write,
    input  i_b_req, iv_b_addr, i_b_addr_fixed, iv_b_wdata, i_b_write,
    input  i_rsp_wr, iv_rsp_addr, i_rsp_addr_fixed, iv_rsp_rdata,
    output o_a_ack, ov_a_rdata, o_a_err,
    output o_b_ack, ov_b_rdata, o_b_err,
    output o_wr, o_rd, ov_addr, o_addr_fixed, ov_wdata
  );

  modport slave (
    output i_a_req, iv_a_addr, i_a_addr_fixed, iv_a_wdata, i_a_write,
    output i_b_req, iv_b_addr, i_b_addr_fixed, iv_b_wdata, i_b_write,
    output i_rsp_wr, iv_rsp_addr, i_rsp_addr_fixed, iv_rsp_rdata,
    input  o_a_ack, ov_a_rdata, o_a_err,
    input  o_b_ack, ov_b_rdata, o_b_err,
    input  o_wr, o_rd, ov_addr, o_addr_fixed, ov_wdata
  );
endinterface

// File: rtl/cfg_bus_arbiter_rr.sv
// Two-way round-robin pick; the last-grant history lives in the parent.
module cfg_rr_arbiter2
  import cfg_bus_pkg::*;
(
  input  logic req_a,
  input  logic req_b,
  input  logic last_grant,
  output logic grant,
  output logic valid
);

  // On a tie the requester not served last wins; otherwise whoever asks.
  always_comb begin
    valid = req_a | req_b;
    grant = REQ_A;
    if (req_a && req_b) begin
      grant = (last_grant == REQ_A) ? REQ_B : REQ_A;
    end else if (req_b) begin
      grant = REQ_B;
    end
  end

endmodule

// File: rtl/cfg_bus_arbiter.sv
// Shares the config bus between two masters: one transaction at a time,
// read responses routed back to the issuer, missing responses timed out.
module cfg_bus_arbiter
  import cfg_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  cfg_bus_arbiter_if.master bus,
  output logic [TCNT_W-1:0] ov_timeout_cnt
);

  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  // Timer holds the number of completed WAIT_RSP cycles; the cycle where it
  // equals TIMEOUT_CYCLES-1 is the last one in which a response is accepted.
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  state_t            state_q, state_d;
  logic              last_grant_q;
  logic              gnt_q;
  logic              write_q;
  logic              fixed_q;
  logic              err_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic [TMR_W-1:0]  timer_q;
  logic              pick;
  logic              pick_valid;
  logic              rsp_match;
  logic              timed_out;

  cfg_rr_arbiter2 u_rr (
    .req_a      (bus.i_a_req),
    .req_b      (bus.i_b_req),
    .last_grant (last_grant_q),
    .grant      (pick),
    .valid      (pick_valid)
  );

  assign rsp_match = bus.i_rsp_wr && (bus.iv_rsp_addr == addr_q) &&
                     (bus.i_rsp_addr_fixed == fixed_q);
  assign timed_out = (timer_q == TMR_LAST);

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state and bus/ack outputs, all decoded from registered state.
  always_comb begin
    state_d          = state_q;
    bus.o_wr         = 1'b0;
    bus.o_rd         = 1'b0;
    bus.ov_addr      = '0;
    bus.o_addr_fixed = 1'b0;
    bus.ov_wdata     = '0;
    bus.o_a_ack      = 1'b0;
    bus.ov_a_rdata   = '0;
    bus.o_a_err      = 1'b0;
    bus.o_b_ack      = 1'b0;
    bus.ov_b_rdata   = '0;
    bus.o_b_err      = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_valid) state_d = ISSUE;
      end
      ISSUE: begin
        bus.o_wr         = write_q;
        bus.o_rd         = !write_q;
        bus.ov_addr      = addr_q;
        bus.o_addr_fixed = fixed_q;
        bus.ov_wdata     = wdata_q;
        state_d          = write_q ? HOLD : WAIT_RSP;
      end
      WAIT_RSP: begin
        if (rsp_match || timed_out) state_d = HOLD;
      end
      HOLD: begin
        if (gnt_q == REQ_A) begin
          bus.o_a_ack    = 1'b1;
          bus.ov_a_rdata = rdata_q;
          bus.o_a_err    = err_q;
        end else begin
          bus.o_b_ack    = 1'b1;
          bus.ov_b_rdata = rdata_q;
          bus.o_b_err    = err_q;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Transaction capture, response/timeout handling and timeout counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      last_grant_q   <= REQ_B;
      gnt_q          <= REQ_A;
      write_q        <= 1'b0;
      fixed_q        <= 1'b0;
      err_q          <= 1'b0;
      addr_q         <= '0;
      wdata_q        <= '0;
      rdata_q        <= '0;
      timer_q        <= '0;
      ov_timeout_cnt <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_valid) begin
            gnt_q        <= pick;
            last_grant_q <= pick;
            if (pick == REQ_A) begin
              addr_q  <= bus.iv_a_addr;
              fixed_q <= bus.i_a_addr_fixed;
              wdata_q <= bus.iv_a_wdata;
              write_q <= bus.i_a_write;
            end else begin
              addr_q  <= bus.iv_b_addr;
              fixed_q <= bus.i_b_addr_fixed;
              wdata_q <= bus.iv_b_wdata;
              write_q <= bus.i_b_write;
            end
          end
        end
        ISSUE: begin
          timer_q <= '0;
          rdata_q <= '0;
          err_q   <= 1'b0;
        end
        WAIT_RSP: begin
          if (rsp_match) begin
            rdata_q <= bus.iv_rsp_rdata;
          end else if (timed_out) begin
            err_q <= 1'b1;
            if (ov_timeout_cnt != '1) ov_timeout_cnt <= ov_timeout_cnt + 1'b1;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cfg_bus_arbiter.sv
// Randomised self-checking bench for cfg_bus_arbiter against a
// transaction-level timing model.
module tb_cfg_bus_arbiter;
  import cfg_bus_pkg::*;

  localparam int TO = 16;

  typedef struct {
    bit          valid;
    logic [18:0] addr;
    logic        fixed;
    logic [31:0] wdata;
    logic        write;
  } req_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] timeout_cnt;

  cfg_bus_arbiter_if bus();

  cfg_bus_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .bus            (bus),
    .ov_timeout_cnt (timeout_cnt)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  req_t        pend[2];
  int          last_w;
  logic [15:0] tcnt;

  task automatic check(input string tag, input logic [143:0] got, input logic [143:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [143:0] obs();
    logic [143:0] v;
    v = '0;
    v[137:0] = {bus.o_wr, bus.o_rd, bus.ov_addr, bus.o_addr_fixed, bus.ov_wdata,
                bus.o_a_ack, bus.ov_a_rdata, bus.o_a_err,
                bus.o_b_ack, bus.ov_b_rdata, bus.o_b_err, timeout_cnt};
    return v;
  endfunction

  function automatic logic [143:0] exp_vec(input logic wr, input logic rd, input logic [18:0] addr,
                                           input logic fixed, input logic [31:0] wdata,
                                           input logic [1:0] ack, input logic [31:0] rd_a,
                                           input logic [31:0] rd_b, input logic [1:0] err,
                                           input logic [15:0] cnt);
    logic [143:0] v;
    v = '0;
    v[137:0] = {wr, rd, addr, fixed, wdata, ack[0], rd_a, err[0], ack[1], rd_b, err[1], cnt};
    return v;
  endfunction

  function automatic req_t new_req();
    req_t r;
    r.valid = 1'b1;
    r.addr  = 19'($urandom);
    r.fixed = 1'($urandom);
    r.wdata = $urandom;
    r.write = 1'($urandom);
    return r;
  endfunction

  task automatic drive_reqs();
    bus.i_a_req        = pend[0].valid;
    bus.iv_a_addr      = pend[0].addr;
    bus.i_a_addr_fixed = pend[0].fixed;
    bus.iv_a_wdata     = pend[0].wdata;
    bus.i_a_write      = pend[0].write;
    bus.i_b_req        = pend[1].valid;
    bus.iv_b_addr      = pend[1].addr;
    bus.i_b_addr_fixed = pend[1].fixed;
    bus.iv_b_wdata     = pend[1].wdata;
    bus.i_b_write      = pend[1].write;
  endtask

  task automatic quiet_rsp(input bit any_wr);
    bus.i_rsp_wr         = any_wr ? 1'($urandom) : 1'b0;
    bus.iv_rsp_addr      = 19'($urandom);
    bus.i_rsp_addr_fixed = 1'($urandom);
    bus.iv_rsp_rdata     = $urandom;
  endtask

  task automatic idle_cycle(input string tag);
    @(negedge clk);
    check(tag, obs(), exp_vec(0, 0, '0, 0, '0, 2'b00, '0, '0, 2'b00, tcnt));
    drive_reqs();
    quiet_rsp(1'b1);
  endtask

  // One transaction from the IDLE sample cycle (c=0) through the ack cycle.
  // lat: cycles from strobe to slave response (0 = no responder).
  task automatic run_round(input int lat, input logic [31:0] data, input bit noise,
                           input int inj_c, input string tag);
    int          w;
    int          ack_c;
    bit          wr;
    bit          match;
    req_t        r;
    logic [1:0]  eack;
    logic [1:0]  eerr;
    logic [31:0] erd_a;
    logic [31:0] erd_b;
    if (pend[0].valid && pend[1].valid) w = (last_w == 0) ? 1 : 0;
    else w = pend[1].valid ? 1 : 0;
    last_w = w;
    r      = pend[w];
    wr     = r.write;
    match  = !wr && lat >= 1 && lat <= TO;
    ack_c  = wr ? 2 : (match ? 2 + lat : TO + 2);
    for (int c = 0; c <= ack_c; c++) begin
      @(negedge clk);
      eack = 2'b00; eerr = 2'b00; erd_a = '0; erd_b = '0;
      if (c == ack_c) begin
        if (!wr && !match && tcnt != 16'hffff) tcnt = tcnt + 16'd1;
        eack[w] = 1'b1;
        eerr[w] = !wr && !match;
        if (w == 0) erd_a = match ? data : 32'd0;
        else        erd_b = match ? data : 32'd0;
      end
      if (c == 1)
        check($sformatf("%s_c%0d", tag, c), obs(),
              exp_vec(wr, !wr, r.addr, r.fixed, r.wdata, eack, erd_a, erd_b, eerr, tcnt));
      else
        check($sformatf("%s_c%0d", tag, c), obs(),
              exp_vec(0, 0, '0, 0, '0, eack, erd_a, erd_b, eerr, tcnt));
      if (c == ack_c) pend[w].valid = 1'b0;
      if (noise && c >= 1 && c < ack_c && !pend[1-w].valid && $urandom_range(0, 7) == 0)
        pend[1-w] = new_req();
      drive_reqs();
      quiet_rsp(1'b0);
      if (match && c == 1 + lat) begin
        bus.i_rsp_wr = 1'b1; bus.iv_rsp_addr = r.addr;
        bus.i_rsp_addr_fixed = r.fixed; bus.iv_rsp_rdata = data;
      end else if (c == inj_c) begin
        bus.i_rsp_wr = 1'b1; bus.iv_rsp_addr = r.addr ^ 19'd1; bus.i_rsp_addr_fixed = r.fixed;
      end else if (!wr && lat == TO + 1 && c == ack_c) begin
        bus.i_rsp_wr = 1'b1; bus.iv_rsp_addr = r.addr;
        bus.i_rsp_addr_fixed = r.fixed; bus.iv_rsp_rdata = data;
      end else if (noise && c >= 2 && c < ack_c && $urandom_range(0, 2) == 0) begin
        bus.i_rsp_wr = 1'b1;
        if ($urandom_range(0, 1) == 0) begin
          bus.iv_rsp_addr = r.addr ^ 19'($urandom_range(1, 19'h7ffff));
          bus.i_rsp_addr_fixed = r.fixed;
        end else begin
          bus.iv_rsp_addr = r.addr;
          bus.i_rsp_addr_fixed = ~r.fixed;
        end
      end
    end
  endtask

  task automatic reset_mid_wait();
    pend[0] = '{1'b1, 19'd9, 1'b0, 32'd0, 1'b0};
    pend[1].valid = 1'b0;
    for (int c = 0; c <= 3; c++) begin
      @(negedge clk);
      if (c == 1)
        check("rst_strobe", obs(), exp_vec(0, 1, 19'd9, 0, '0, 2'b00, '0, '0, 2'b00, tcnt));
      drive_reqs();
      quiet_rsp(1'b0);
    end
    rst_n = 1'b0;
    pend[0].valid = 1'b0;
    drive_reqs();
    last_w = 1;
    tcnt   = '0;
    @(negedge clk);
    check("rst_hold", obs(), exp_vec(0, 0, '0, 0, '0, 2'b00, '0, '0, 2'b00, tcnt));
    rst_n = 1'b1;
    bus.i_rsp_wr = 1'b1; bus.iv_rsp_addr = 19'd9;
    bus.i_rsp_addr_fixed = 1'b0; bus.iv_rsp_rdata = 32'hdead_beef;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("rst_after_c%0d", c), obs(),
            exp_vec(0, 0, '0, 0, '0, 2'b00, '0, '0, 2'b00, tcnt));
      quiet_rsp(1'b0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    pend[0] = '{1'b0, '0, 1'b0, '0, 1'b0};
    pend[1] = '{1'b0, '0, 1'b0, '0, 1'b0};
    last_w  = 1;
    tcnt    = '0;
    drive_reqs();
    quiet_rsp(1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset", obs(), exp_vec(0, 0, '0, 0, '0, 2'b00, '0, '0, 2'b00, 16'd0));
    rst_n = 1'b1;

    pend[0] = '{1'b1, 19'd3, 1'b1, 32'h1, 1'b1};
    run_round(0, '0, 1'b0, -1, "wr_a");

    pend[1] = '{1'b1, 19'd5, 1'b1, 32'h0, 1'b0};
    run_round(1, 32'h4, 1'b0, -1, "rd_b");

    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 2; k++)
        if (!pend[k].valid) pend[k] = '{1'b1, 19'($urandom), 1'($urandom), $urandom, 1'b0};
      run_round(1, $urandom, 1'b0, -1, $sformatf("rr%0d", i));
    end
    run_round(1, $urandom, 1'b0, -1, "rr_tail");

    pend[0] = '{1'b1, 19'd7, 1'b0, 32'h0, 1'b0};
    run_round(0, '0, 1'b0, 8, "timeout");

    pend[1] = '{1'b1, 19'h1234, 1'b1, 32'h0, 1'b0};
    run_round(TO, 32'hcafe_0001, 1'b0, -1, "last_cycle");

    pend[0] = '{1'b1, 19'h55, 1'b0, 32'h0, 1'b0};
    run_round(TO + 1, 32'h1111_2222, 1'b0, -1, "late_rsp");

    reset_mid_wait();
    pend[0] = '{1'b1, 19'h42, 1'b0, 32'h0, 1'b0};
    run_round(2, 32'h0bad_f00d, 1'b0, -1, "post_rst");

    for (int n = 0; n < 200; n++) begin
      for (int k = 0; k < 2; k++)
        if (!pend[k].valid && $urandom_range(0, 3) != 0) pend[k] = new_req();
      if (!pend[0].valid && !pend[1].valid) idle_cycle("idle");
      else run_round($urandom_range(0, TO + 1), $urandom, 1'b1, -1, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
